// File: rtl/calc_pkg.sv
// Shared types and 7-segment constants for the calculator result display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_R     = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        res = 12'd0;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational display-code to 7-segment pattern decoder.
// Codes 0-9 are digits, A is 'E', B is 'r', everything else is blank.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Code lookup; unused codes fall back to blank.
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            CODE_E:  seg_o = SEG_E;
            CODE_R:  seg_o = SEG_R;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures the calculator result on each done rising edge, converts it to BCD
// and drives a 4-digit multiplexed 7-segment display ("Err" on error).
module calc_result_display
    import calc_pkg::*;
#(
    parameter int SCAN_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       error,
    input  logic [3:0] out_h,
    input  logic [3:0] out_l,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy,
    output logic       valid
);

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [19:0]          sr_q, sr_d;
    logic                 err_sel_q, err_sel_d;
    logic                 pend_q, pend_d;
    logic [7:0]           pend_v_q, pend_v_d;
    logic                 pend_err_q, pend_err_d;
    logic [3:0][3:0]      digit_q, digit_d;
    logic                 valid_q, valid_d;
    logic                 busy_q;
    logic                 done_q;
    logic [SCAN_BITS-1:0] scan_q;
    logic [1:0]           idx_q;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic       cap;
    logic [7:0] v;
    logic       launch;
    logic [7:0] launch_v;
    logic       launch_err;

    assign v   = {out_h, out_l};
    assign cap = done & ~done_q;

    // Next-state: conversion FSM, one-deep pending slot and display digit registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        err_sel_d  = err_sel_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        pend_err_d = pend_err_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        launch     = 1'b0;
        launch_v   = v;
        launch_err = error;
        case (state_q)
            IDLE: begin
                launch = cap;
            end
            CONV: begin
                sr_d  = {bcd_adjust(sr_q[19:8]), sr_q[7:0]} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = UPD;
                end else begin
                    state_d = CONV;
                end
                if (cap) begin
                    pend_d     = 1'b1;
                    pend_v_d   = v;
                    pend_err_d = error;
                end else begin
                    pend_d = pend_q;
                end
            end
            UPD: begin
                if (err_sel_q) begin
                    digit_d = {CODE_BLANK, CODE_E, CODE_R, CODE_R};
                end else begin
                    digit_d[3] = CODE_BLANK;
                    digit_d[2] = (sr_q[19:16] == 4'd0) ? CODE_BLANK : sr_q[19:16];
                    digit_d[1] = (sr_q[19:12] == 8'd0) ? CODE_BLANK : sr_q[15:12];
                    digit_d[0] = sr_q[11:8];
                end
                valid_d = 1'b1;
                state_d = IDLE;
                launch  = pend_q | cap;
                // A stored operand goes first; a simultaneous capture takes its slot.
                if (pend_q) begin
                    launch_v   = pend_v_q;
                    launch_err = pend_err_q;
                    pend_d     = cap;
                    pend_v_d   = v;
                    pend_err_d = error;
                end else begin
                    pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (launch) begin
            if (launch_err) begin
                state_d   = UPD;
                err_sel_d = 1'b1;
            end else begin
                state_d   = CONV;
                sr_d      = {12'd0, launch_v};
                cnt_d     = 3'd0;
                err_sel_d = 1'b0;
            end
        end else begin
            err_sel_d = err_sel_d;
        end
    end

    seg7_decode u_dec (
        .code_i (digit_q[idx_q]),
        .seg_o  (seg_d)
    );

    assign an_d = ~(4'b0001 << idx_q);

    // State, scan counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sr_q       <= 20'd0;
            err_sel_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_v_q   <= 8'd0;
            pend_err_q <= 1'b0;
            digit_q    <= {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd0};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scan_q     <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= SEG_0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            err_sel_q  <= err_sel_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            pend_err_q <= pend_err_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= done;
            scan_q     <= scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            if (&scan_q) begin
                idx_q <= idx_q + 2'd1;
            end else begin
                idx_q <= idx_q;
            end
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Randomised bench for calc_result_display with a job-level reference model
// (capture times, pending slot, decimal rendering) checked every cycle.
module tb_calc_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done = 1'b0;
    logic       error = 1'b0;
    logic [3:0] out_h = 4'd0;
    logic [3:0] out_l = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    calc_result_display #(.SCAN_BITS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .done  (done),
        .error (error),
        .out_h (out_h),
        .out_l (out_l),
        .an    (an),
        .seg   (seg),
        .busy  (busy),
        .valid (valid)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BL = 7'h7F;
    logic [6:0] dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state
    logic [6:0] m_disp [4];
    bit         m_busy, m_pend, m_valid, m_done_prev, m_cur_err, m_perr;
    logic [7:0] m_cur_v, m_pv;
    int         m_cycle = 0, m_upd = 0, m_cnt = 0, m_idx = 0, n_upd = 0;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    bit         m_started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic render(input logic [7:0] v, input bit e);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        m_disp[3] = BL;
        if (e) begin
            m_disp[2] = 7'b0000110;
            m_disp[1] = 7'b0101111;
            m_disp[0] = 7'b0101111;
        end else begin
            m_disp[2] = (h != 0) ? dig_tab[h] : BL;
            m_disp[1] = (h != 0 || t != 0) ? dig_tab[t] : BL;
            m_disp[0] = dig_tab[o];
        end
    endtask

    task automatic start_job(input logic [7:0] v, input bit e);
        m_busy    = 1;
        m_cur_v   = v;
        m_cur_err = e;
        m_upd     = m_cycle + (e ? 1 : 9);
    endtask

    task automatic model_step();
        bit cap;
        logic [7:0] v;
        if (!rst) begin
            m_busy = 0; m_pend = 0; m_valid = 0; m_done_prev = 0;
            m_cnt = 0; m_idx = 0; m_an = 4'b1110; m_seg = 7'b1000000;
            m_disp[3] = BL; m_disp[2] = BL; m_disp[1] = BL; m_disp[0] = 7'b1000000;
        end else begin
            cap = done && !m_done_prev;
            m_done_prev = done;
            v = {out_h, out_l};
            m_an  = ~(4'b0001 << m_idx);
            m_seg = m_disp[m_idx];
            if (m_cnt == 3) m_idx = (m_idx + 1) % 4;
            m_cnt = (m_cnt + 1) % 4;
            if (!m_busy) begin
                if (cap) start_job(v, error);
            end else if (m_cycle == m_upd) begin
                render(m_cur_v, m_cur_err);
                m_valid = 1;
                n_upd++;
                if (m_pend) begin
                    start_job(m_pv, m_perr);
                    m_pend = cap; m_pv = v; m_perr = error;
                end else if (cap) begin
                    start_job(v, error);
                end else begin
                    m_busy = 0;
                end
            end else if (cap) begin
                m_pend = 1; m_pv = v; m_perr = error;
            end
        end
        m_cycle++;
    endtask

    // Model advance and per-cycle output comparison, 1 time unit after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        model_step();
        chk("an", {28'd0, an}, {28'd0, m_an});
        chk("seg", {25'd0, seg}, {25'd0, m_seg});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v, input logic e, input int hold);
        out_h = v[7:4]; out_l = v[3:0]; error = e; done = 1'b1;
        cyc(hold);
        done = 1'b0;
    endtask

    task automatic chk_disp(input string name, input logic [27:0] exp);
        chk(name, {4'd0, m_disp[3], m_disp[2], m_disp[1], m_disp[0]}, {4'd0, exp});
    endtask

    initial begin
        int base, w;
        bit seen;
        cyc(3);
        chk("rst_an", {28'd0, an}, 32'hE);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        cyc(5);
        chk("scan_rot", {28'd0, an}, 32'hD);

        pulse(8'hFF, 1'b0, 1);
        chk("lat_busy_c1", {31'd0, busy}, 32'd1);
        cyc(8);
        chk("lat_busy_c9", {31'd0, busy}, 32'd1);
        cyc(1);
        chk("lat_busy_c10", {31'd0, busy}, 32'd0);
        chk("lat_valid", {31'd0, valid}, 32'd1);
        chk_disp("disp_255", {BL, 7'h24, 7'h12, 7'h12});

        pulse(8'h07, 1'b0, 2);
        cyc(12);
        chk_disp("disp_7", {BL, BL, BL, 7'h78});
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (an == 4'b1110) seen = 1; else cyc(1);
        end
        chk("d0_seen", {31'd0, seen}, 32'd1);
        chk("d0_seg7", {25'd0, seg}, 32'h78);

        pulse(8'h0A, 1'b0, 1);
        cyc(12);
        chk_disp("disp_10", {BL, BL, 7'h79, 7'h40});

        pulse(8'h00, 1'b1, 1);
        chk("err_busy_c1", {31'd0, busy}, 32'd1);
        cyc(1);
        chk("err_busy_c2", {31'd0, busy}, 32'd0);
        chk_disp("disp_err", {BL, 7'h06, 7'h2F, 7'h2F});
        cyc(3);
        pulse(8'h64, 1'b0, 1);
        cyc(12);
        chk_disp("disp_100", {BL, 7'h79, 7'h40, 7'h40});

        base = n_upd;
        pulse(8'h12, 1'b0, 1);
        cyc(2);
        pulse(8'h34, 1'b0, 1);
        cyc(8);
        chk_disp("disp_18", {BL, BL, 7'h79, 7'h00});
        cyc(15);
        chk_disp("disp_52", {BL, BL, 7'h12, 7'h24});
        chk("two_updates", n_upd - base, 32'd2);

        pulse(8'h99, 1'b0, 1);
        cyc(3);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_seg", {25'd0, seg}, 32'h40);
        chk_disp("disp_rst", {BL, BL, BL, 7'h40});

        out_h = 4'h0; out_l = 4'h5; error = 1'b0; done = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        base = n_upd;
        rst = 1'b1;
        cyc(30);
        done = 1'b0;
        chk("held_done_once", n_upd - base, 32'd1);
        chk_disp("disp_5", {BL, BL, BL, 7'h12});

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                cyc($urandom_range(1, 2));
                rst = 1'b1;
            end
            pulse(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                  $urandom_range(1, 3));
            w = $urandom_range(1, 14);
            cyc(w);
        end
        cyc(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
